// File: rtl/core_pkg.sv
// Shared types and encodings for the multicycle RV32I-subset core control path.
package core_pkg;

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRead, StMemWb, StMemWrite,
    StExecR, StExecI, StAluWb, StBeq, StJal
  } state_e;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASSA = 3'b111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALUOp plus instruction funct fields to the ALU operation code.
module alu_decoder
  import core_pkg::*;
(
  input  logic [1:0] ALUOp,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] ALUControl
);

  always_comb begin
    ALUControl = ALU_PASSA;
    unique case (ALUOp)
      ALUOP_ADD: ALUControl = ALU_ADD;
      ALUOP_SUB: ALUControl = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct3)
          // Only R-type (op[5] set) can subtract; I-type funct7 bits are immediate.
          3'b000:  ALUControl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b110:  ALUControl = ALU_OR;
          3'b111:  ALUControl = ALU_AND;
          default: ALUControl = ALU_PASSA;
        endcase
      end
      default: ALUControl = ALU_PASSA;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM of the multicycle core: sequences each instruction and drives
// every datapath select and enable; immediate format is decoded from the opcode.
module multicycle_control
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       RegWrite,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl
);

  state_e     state, state_next;
  logic [1:0] alu_op;
  logic       pc_update, branch, ir_write, mem_write, reg_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= StFetch;
    else       state <= state_next;
  end

  always_comb begin
    state_next = StFetch;
    alu_op     = ALUOP_ADD;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RS2;
    unique case (state)
      StFetch: begin
        ir_write   = 1'b1;
        pc_update  = 1'b1;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        state_next = StDecode;
      end
      StDecode: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        unique case (op)
          OP_LW, OP_SW: state_next = StMemAdr;
          OP_RTYPE:     state_next = StExecR;
          OP_IALU:      state_next = StExecI;
          OP_BEQ:       state_next = StBeq;
          OP_JAL:       state_next = StJal;
          default:      state_next = StFetch;
        endcase
      end
      StMemAdr: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        state_next = (op == OP_LW) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        AdrSrc     = 1'b1;
        state_next = StMemWb;
      end
      StMemWb: begin
        ResultSrc = RES_DATA;
        reg_write = 1'b1;
      end
      StMemWrite: begin
        AdrSrc    = 1'b1;
        mem_write = 1'b1;
      end
      StExecR: begin
        ALUSrcA    = SRCA_RS1;
        alu_op     = ALUOP_FUNCT;
        state_next = StAluWb;
      end
      StExecI: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        alu_op     = ALUOP_FUNCT;
        state_next = StAluWb;
      end
      StAluWb: reg_write = 1'b1;
      StBeq: begin
        ALUSrcA = SRCA_RS1;
        alu_op  = ALUOP_SUB;
        branch  = 1'b1;
      end
      StJal: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        pc_update  = 1'b1;
        state_next = StAluWb;
      end
      default: state_next = StFetch;
    endcase
  end

  // Reset already forces StFetch; gate the enables FETCH would otherwise raise.
  assign PCWrite  = ~reset & (pc_update | (branch & zero));
  assign IRWrite  = ~reset & ir_write;
  assign MemWrite = ~reset & mem_write;
  assign RegWrite = ~reset & reg_write;

  always_comb begin
    unique case (op)
      OP_LW, OP_IALU: ImmSrc = 2'b00;
      OP_SW:          ImmSrc = 2'b01;
      OP_BEQ:         ImmSrc = 2'b10;
      OP_JAL:         ImmSrc = 2'b11;
      default:        ImmSrc = 2'b00;
    endcase
  end

  alu_decoder u_alu_decoder (
    .ALUOp      (alu_op),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .ALUControl (ALUControl)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven bench for the multicycle control FSM with reset corner cases.
module tb_multicycle_control;

  typedef struct packed {
    logic       pcw, adr, mw, irw;
    logic [1:0] rs, sa, sb;
    logic       rw;
    logic [1:0] imm;
    logic [2:0] alu;
  } outs_t;

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    outs_t      exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .PCWrite    (PCWrite),
    .AdrSrc     (AdrSrc),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .ResultSrc  (ResultSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .RegWrite   (RegWrite),
    .ImmSrc     (ImmSrc),
    .ALUControl (ALUControl)
  );

  function automatic outs_t o(input logic pcw, input logic adr, input logic mw, input logic irw,
                              input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                              input logic rw, input logic [1:0] imm, input logic [2:0] alu);
    return {pcw, adr, mw, irw, rs, sa, sb, rw, imm, alu};
  endfunction

  task automatic add(input string n, input logic [6:0] vop, input logic [2:0] f3, input logic f7,
                     input logic z, input outs_t e);
    vec_t v;
    v.name = n; v.op = vop; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input outs_t e);
    outs_t got;
    got = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite, ImmSrc,
           ALUControl};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s got pcw/adr/mw/irw/rs/sa/sb/rw/imm/alu=%b required %b", n, got, e);
    end
  endtask

  initial begin
    // lw
    add("lw_fetch",   7'b0000011, 3'b010, 1'b0, 1'b0, o(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,3'b000));
    add("lw_decode",  7'b0000011, 3'b010, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,3'b000));
    add("lw_memadr",  7'b0000011, 3'b010, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b10,2'b01,0,2'b00,3'b000));
    add("lw_memread", 7'b0000011, 3'b010, 1'b0, 1'b0, o(0,1,0,0,2'b00,2'b00,2'b00,0,2'b00,3'b000));
    add("lw_memwb",   7'b0000011, 3'b010, 1'b0, 1'b0, o(0,0,0,0,2'b01,2'b00,2'b00,1,2'b00,3'b000));
    // sw
    add("sw_fetch",   7'b0100011, 3'b010, 1'b0, 1'b0, o(1,0,0,1,2'b10,2'b00,2'b10,0,2'b01,3'b000));
    add("sw_decode",  7'b0100011, 3'b010, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b01,2'b01,0,2'b01,3'b000));
    add("sw_memadr",  7'b0100011, 3'b010, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b10,2'b01,0,2'b01,3'b000));
    add("sw_memwr",   7'b0100011, 3'b010, 1'b0, 1'b0, o(0,1,1,0,2'b00,2'b00,2'b00,0,2'b01,3'b000));
    // R-type sub, then add
    add("sub_fetch",  7'b0110011, 3'b000, 1'b1, 1'b0, o(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,3'b000));
    add("sub_decode", 7'b0110011, 3'b000, 1'b1, 1'b0, o(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,3'b000));
    add("sub_execr",  7'b0110011, 3'b000, 1'b1, 1'b0, o(0,0,0,0,2'b00,2'b10,2'b00,0,2'b00,3'b001));
    add("sub_aluwb",  7'b0110011, 3'b000, 1'b1, 1'b0, o(0,0,0,0,2'b00,2'b00,2'b00,1,2'b00,3'b000));
    add("add_fetch",  7'b0110011, 3'b000, 1'b0, 1'b0, o(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,3'b000));
    add("add_decode", 7'b0110011, 3'b000, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,3'b000));
    add("add_execr",  7'b0110011, 3'b000, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b10,2'b00,0,2'b00,3'b000));
    add("add_aluwb",  7'b0110011, 3'b000, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b00,2'b00,1,2'b00,3'b000));
    // I-ALU ori, andi, addi with funct7b5 set (no subtract)
    add("ori_fetch",  7'b0010011, 3'b110, 1'b0, 1'b0, o(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,3'b000));
    add("ori_decode", 7'b0010011, 3'b110, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,3'b000));
    add("ori_execi",  7'b0010011, 3'b110, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b10,2'b01,0,2'b00,3'b011));
    add("ori_aluwb",  7'b0010011, 3'b110, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b00,2'b00,1,2'b00,3'b000));
    add("andi_fetch", 7'b0010011, 3'b111, 1'b0, 1'b0, o(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,3'b000));
    add("andi_dec",   7'b0010011, 3'b111, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,3'b000));
    add("andi_execi", 7'b0010011, 3'b111, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b10,2'b01,0,2'b00,3'b010));
    add("andi_aluwb", 7'b0010011, 3'b111, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b00,2'b00,1,2'b00,3'b000));
    add("addi_fetch", 7'b0010011, 3'b000, 1'b1, 1'b0, o(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,3'b000));
    add("addi_dec",   7'b0010011, 3'b000, 1'b1, 1'b0, o(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,3'b000));
    add("addi_execi", 7'b0010011, 3'b000, 1'b1, 1'b0, o(0,0,0,0,2'b00,2'b10,2'b01,0,2'b00,3'b000));
    add("addi_aluwb", 7'b0010011, 3'b000, 1'b1, 1'b0, o(0,0,0,0,2'b00,2'b00,2'b00,1,2'b00,3'b000));
    // beq taken (zero held high, must be ignored outside BEQ), then not taken
    add("beqt_fetch", 7'b1100011, 3'b000, 1'b0, 1'b1, o(1,0,0,1,2'b10,2'b00,2'b10,0,2'b10,3'b000));
    add("beqt_dec",   7'b1100011, 3'b000, 1'b0, 1'b1, o(0,0,0,0,2'b00,2'b01,2'b01,0,2'b10,3'b000));
    add("beqt_beq",   7'b1100011, 3'b000, 1'b0, 1'b1, o(1,0,0,0,2'b00,2'b10,2'b00,0,2'b10,3'b001));
    add("beqn_fetch", 7'b1100011, 3'b000, 1'b0, 1'b0, o(1,0,0,1,2'b10,2'b00,2'b10,0,2'b10,3'b000));
    add("beqn_dec",   7'b1100011, 3'b000, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b01,2'b01,0,2'b10,3'b000));
    add("beqn_beq",   7'b1100011, 3'b000, 1'b0, 1'b0, o(0,0,0,0,2'b00,2'b10,2'b00,0,2'b10,3'b001));
    // jal
    add("jal_fetch",  7'b1101111, 3'b000, 1'b0, 1'b1, o(1,0,0,1,2'b10,2'b00,2'b10,0,2'b11,3'b000));
    add("jal_decode", 7'b1101111, 3'b000, 1'b0, 1'b1, o(0,0,0,0,2'b00,2'b01,2'b01,0,2'b11,3'b000));
    add("jal_jal",    7'b1101111, 3'b000, 1'b0, 1'b1, o(1,0,0,0,2'b00,2'b01,2'b10,0,2'b11,3'b000));
    add("jal_aluwb",  7'b1101111, 3'b000, 1'b0, 1'b1, o(0,0,0,0,2'b00,2'b00,2'b00,1,2'b11,3'b000));
    // illegal opcode: DECODE then straight back to FETCH
    add("ill_fetch",  7'b1111111, 3'b000, 1'b0, 1'b1, o(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,3'b000));
    add("ill_decode", 7'b1111111, 3'b000, 1'b0, 1'b1, o(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,3'b000));
    add("ill_refetch",7'b1111111, 3'b000, 1'b0, 1'b1, o(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,3'b000));

    // Reset state: enables forced low, FETCH selects, ImmSrc follows op.
    op = 7'b0100011;
    #1 check("reset_state", o(0,0,0,0,2'b10,2'b00,2'b10,0,2'b01,3'b000));
    repeat (2) @(posedge clk);
    #1 check("reset_hold", o(0,0,0,0,2'b10,2'b00,2'b10,0,2'b01,3'b000));
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      op = vecs[i].op; funct3 = vecs[i].f3; funct7b5 = vecs[i].f7; zero = vecs[i].z;
      #1 check(vecs[i].name, vecs[i].exp);
      @(negedge clk);
    end

    // Reset in MEMREAD of an lw: abandon, no writes, FETCH on first edge after release.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0;
    repeat (3) @(negedge clk);
    #1 check("rst_lw_memread", o(0,1,0,0,2'b00,2'b00,2'b00,0,2'b00,3'b000));
    #1 reset = 1'b1;
    #1 check("rst_async", o(0,0,0,0,2'b10,2'b00,2'b10,0,2'b00,3'b000));
    @(posedge clk);
    #1 check("rst_no_memwb", o(0,0,0,0,2'b10,2'b00,2'b10,0,2'b00,3'b000));
    @(negedge clk);
    reset = 1'b0;
    #1 check("rst_rel_fetch", o(1,0,0,1,2'b10,2'b00,2'b10,0,2'b00,3'b000));
    @(negedge clk);
    #1 check("rst_rel_decode", o(0,0,0,0,2'b00,2'b01,2'b01,0,2'b00,3'b000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
